// File: rtl/adder_bmf_pipe.sv
// Carry-pipelined approximate adder: one SEG-bit segment per stage, per-transaction carry-cut mask.
// Latency NSEG register stages (acceptance register first); one transaction per cycle.
// Backpressure: in_ready = ~out_valid | out_ready; all stages hold together when it is low.
// Optional error statistics enabled by defining ADDER_BMF_ERRSTAT_EN.
module adder_bmf_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  input  logic [WIDTH/SEG-1:0] in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout
`ifdef ADDER_BMF_ERRSTAT_EN
  ,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     errcnt
`endif
);

  localparam int NSEG = WIDTH / SEG;

  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Each stage consumes the low segment of the operands it receives and forwards the
  // rest shifted down, so unused operand bits never sit in a register.
  for (genvar g = 0; g < NSEG; g++) begin : g_stage
    localparam int RW = WIDTH - g * SEG;

    logic [RW-1:0]         w_arem;
    logic [RW-1:0]         w_brem;
    logic [NSEG-g-1:0]     w_mrem;
    logic                  w_cprev;
    logic                  w_vin;
    logic                  w_cin;
    logic [SEG:0]          w_res;
    logic [(g+1)*SEG-1:0]  w_sum_nxt;
    logic                  r_vld;
    logic                  r_c;
    logic [(g+1)*SEG-1:0]  r_sum;
`ifdef ADDER_BMF_ERRSTAT_EN
    logic                  w_ecprev;
    logic                  w_errprev;
    logic [SEG:0]          w_eres;
    logic                  w_err_nxt;
    logic                  r_err;
`endif

    if (g == 0) begin : g_src
      assign w_arem    = in_a;
      assign w_brem    = in_b;
      assign w_mrem    = in_mask;
      assign w_cprev   = in_cin;
      assign w_vin     = in_valid;
      assign w_sum_nxt = w_res[SEG-1:0];
`ifdef ADDER_BMF_ERRSTAT_EN
      assign w_ecprev  = in_cin;
      assign w_errprev = 1'b0;
`endif
    end else begin : g_src
      assign w_arem    = g_stage[g-1].g_fwd.r_a;
      assign w_brem    = g_stage[g-1].g_fwd.r_b;
      assign w_mrem    = g_stage[g-1].g_fwd.r_m;
      assign w_cprev   = g_stage[g-1].r_c;
      assign w_vin     = g_stage[g-1].r_vld;
      assign w_sum_nxt = {w_res[SEG-1:0], g_stage[g-1].r_sum};
`ifdef ADDER_BMF_ERRSTAT_EN
      assign w_ecprev  = g_stage[g-1].g_fwd.r_ec;
      assign w_errprev = g_stage[g-1].r_err;
`endif
    end

    // An approximate segment drops its incoming carry but still produces its own carry-out.
    assign w_cin = w_mrem[0] ? 1'b0 : w_cprev;
    assign w_res = {1'b0, w_arem[SEG-1:0]} + {1'b0, w_brem[SEG-1:0]} + {{SEG{1'b0}}, w_cin};

    // Stage register: valid, accumulated sum bits and this segment's carry-out.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vin;
        r_c   <= w_res[SEG];
        r_sum <= w_sum_nxt;
      end
    end

`ifdef ADDER_BMF_ERRSTAT_EN
    // Exact chain ignores the mask; a mismatch in any segment (or the final carry) flags the result.
    assign w_eres = {1'b0, w_arem[SEG-1:0]} + {1'b0, w_brem[SEG-1:0]} + {{SEG{1'b0}}, w_ecprev};
    if (g == NSEG - 1) begin : g_errlast
      assign w_err_nxt = w_errprev | (w_eres != w_res);
    end else begin : g_errmid
      assign w_err_nxt = w_errprev | (w_eres[SEG-1:0] != w_res[SEG-1:0]);
    end

    // Running mismatch flag travels with the transaction.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_err <= 1'b0;
      end else if (w_adv) begin
        r_err <= w_err_nxt;
      end
    end
`endif

    if (g < NSEG - 1) begin : g_fwd
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;
      logic [NSEG-g-2:0] r_m;
`ifdef ADDER_BMF_ERRSTAT_EN
      logic              r_ec;
`endif

      // Operands and mask bits for segments not yet processed.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_m <= '0;
`ifdef ADDER_BMF_ERRSTAT_EN
          r_ec <= 1'b0;
`endif
        end else if (w_adv) begin
          r_a <= w_arem[RW-1:SEG];
          r_b <= w_brem[RW-1:SEG];
          r_m <= w_mrem[NSEG-g-1:1];
`ifdef ADDER_BMF_ERRSTAT_EN
          r_ec <= w_eres[SEG];
`endif
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].r_vld;
  assign out_sum   = g_stage[NSEG-1].r_sum;
  assign out_cout  = g_stage[NSEG-1].r_c;

`ifdef ADDER_BMF_ERRSTAT_EN
  assign out_err = g_stage[NSEG-1].r_err;

  // Saturating count of retired mismatching results; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt <= '0;
    end else if (err_clr) begin
      errcnt <= '0;
    end else if (out_valid && out_ready && out_err && (errcnt != {CNT_W{1'b1}})) begin
      errcnt <= errcnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_bmf_pipe.sv
// Scoreboard bench for adder_bmf_pipe: randomized and directed transactions,
// expected results from a segment-level arithmetic model, checked by a separate monitor.
module tb_adder_bmf_pipe;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int N  = W / S;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [N-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
`ifdef ADDER_BMF_ERRSTAT_EN
  logic          out_err;
  logic          err_clr;
  logic [CW-1:0] errcnt;
`endif

  adder_bmf_pipe #(.WIDTH(W), .SEG(S), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADDER_BMF_ERRSTAT_EN
    ,
    .out_err   (out_err),
    .err_clr   (err_clr),
    .errcnt    (errcnt)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: add segment by segment; a masked segment sees carry-in 0.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic [N-1:0] m);
    logic [W:0] r;
    int c;
    int s;
    r = '0;
    c = int'(cin);
    for (int i = 0; i < N; i++) begin
      s = int'((a >> (i * S)) & 32'hF) + int'((b >> (i * S)) & 32'hF) + (m[i] ? 0 : c);
      r[i*S +: S] = s[S-1:0];
      c = s / 16;
    end
    r[W] = c[0];
    return r;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [N-1:0] m, input logic [W-1:0] esum, input logic ecout,
                      input logic eerr, input bit lat);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_mask  = m;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
    end else begin
      @(posedge clk);
      #1;
      e.sum  = esum;
      e.cout = ecout;
      e.err  = eerr;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat, input bit zero_mask);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [N-1:0] m;
    logic [W:0]   r;
    logic [W:0]   ex;
    a  = $urandom;
    b  = $urandom;
    c  = 1'($urandom_range(0, 1));
    m  = zero_mask ? '0 : N'($urandom);
    r  = model(a, b, c, m);
    ex = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    send(a, b, c, m, r[W-1:0], r[W], r != ex, lat);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: looks just before each rising edge whether a result is being taken.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_cnt = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
`ifdef ADDER_BMF_ERRSTAT_EN
      chk("errcnt", errcnt, exp_cnt);
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: got sum 0x%0h with no expected entry", out_sum);
        end else begin
          mon_e = sb.pop_front();
          chk("sum", out_sum, mon_e.sum);
          chk("cout", out_cout, mon_e.cout);
          if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'(N - 1));
`ifdef ADDER_BMF_ERRSTAT_EN
          chk("out_err", out_err, mon_e.err);
          if (mon_e.err && exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
        end
      end
`ifdef ADDER_BMF_ERRSTAT_EN
      if (err_clr) exp_cnt = 0;
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold;
    int guard;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_mask   = '0;
    out_ready = 1'b1;
`ifdef ADDER_BMF_ERRSTAT_EN
    err_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", out_cout, 1'b0);
`ifdef ADDER_BMF_ERRSTAT_EN
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_errcnt", errcnt, '0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed cases: full carry ripple, masked segment 0, masked segment 1.
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    send(32'h0000_000F, 32'h0, 1'b1, 8'h01, 32'h0000_000F, 1'b0, 1'b1, 1'b1);
    drain();
    send(32'h0000_00FF, 32'h1, 1'b0, 8'h02, 32'h0000_00F0, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back random stream with a 5-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand(1'b0, (i % 4) == 0);
      end
      begin
        repeat (12) @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("stall_valid", out_valid, 1'b1);
        hold = out_sum;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #1;
          end
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_hold", out_sum, hold);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with transactions in flight: nothing stale may emerge afterwards.
    for (int i = 0; i < 3; i++) send_rand(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
`ifdef ADDER_BMF_ERRSTAT_EN
    chk("midrst_errcnt", errcnt, '0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send_rand(1'b1, 1'b0);
    drain();

    // Twenty mismatching results saturate the counter; then clear against a retire.
    for (int i = 0; i < 20; i++)
      send(32'h0000_000F, 32'h0, 1'b1, 8'h01, 32'h0000_000F, 1'b0, 1'b1, 1'b0);
    drain();
`ifdef ADDER_BMF_ERRSTAT_EN
    chk("errcnt_sat", errcnt, 4'hF);
`endif
    send(32'h0000_000F, 32'h0, 1'b1, 8'h01, 32'h0000_000F, 1'b0, 1'b1, 1'b0);
    guard = 0;
    @(negedge clk);
    #1;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("clr_wait_valid", out_valid, 1'b1);
`ifdef ADDER_BMF_ERRSTAT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("errcnt_clr", errcnt, '0);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
